// File: rtl/rvfi_commit_sequencer.sv
// RVFI commit sequencer: serialises multi-port commit records into a single in-order stream
// and stops the simulation after ecall or a cycle timeout, once the buffer has drained.

package rvfi_commit_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] order;
        logic [31:0] insn;
        logic        trap;
        logic        halt;
        logic        intr;
        logic [1:0]  mode;
        logic [1:0]  ixl;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } rvfi_instr_t;

endpackage

module rvfi_commit_sequencer
    import rvfi_commit_pkg::*;
#(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned DEPTH           = 8,
    localparam int unsigned PW = (NR_COMMIT_PORTS > 1) ? $clog2(NR_COMMIT_PORTS) : 1,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned LW = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  rvfi_instr_t       rvfi_i [NR_COMMIT_PORTS],
    input  logic [31:0]       timeout_cycles_i,
    output rvfi_instr_t       out_rvfi_o,
    output logic [PW-1:0]     out_port_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [LW-1:0]     fifo_level_o,
    output logic              overflow_o,
    output logic [31:0]       drop_cnt_o,
    output logic              timeout_o,
    output logic              halt_o
);

    localparam logic [31:0] ECALL_INSN = 32'h0000_0073;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    rvfi_instr_t   r_mem      [DEPTH];
    logic [PW-1:0] r_port_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [31:0]   r_cycle_cnt;
    logic [31:0]   r_drop_cnt;
    logic          r_overflow;
    logic          r_timeout;

    logic [NR_COMMIT_PORTS-1:0] w_elig;
    logic [AW-1:0] w_waddr [NR_COMMIT_PORTS];
    logic [LW-1:0] w_n;
    logic [LW-1:0] w_free;
    logic [LW-1:0] w_push_cnt;
    logic [32:0]   w_drop_sum;
    logic          w_ecall_any;
    logic          w_capture_en;
    logic          w_push_ok;
    logic          w_drop;
    logic          w_pop;
    logic          w_ecall_hit;
    logic          w_timeout_hit;
    logic          w_halt;

    for (genvar gi = 0; gi < NR_COMMIT_PORTS; gi++) begin : g_elig
        assign w_elig[gi] = rvfi_i[gi].valid | rvfi_i[gi].trap;
    end

    // Running count of eligible ports gives each record its slot after the write pointer.
    always_comb begin
        w_n         = '0;
        w_ecall_any = 1'b0;
        for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
            w_waddr[i] = r_wr_ptr + w_n[AW-1:0];
            w_n        = w_n + LW'(w_elig[i]);
            if (rvfi_i[i].valid && (rvfi_i[i].insn == ECALL_INSN)) begin
                w_ecall_any = 1'b1;
            end
        end
    end

    // A pop in the same cycle does not free room for this cycle's capture.
    assign w_free        = LW'(DEPTH) - r_level;
    assign w_push_ok     = w_capture_en && (w_n <= w_free);
    assign w_drop        = w_capture_en && (w_n > w_free);
    assign w_push_cnt    = w_push_ok ? w_n : '0;
    assign w_pop         = (r_level != '0) && out_ready_i;
    assign w_ecall_hit   = w_push_ok && w_ecall_any;
    assign w_timeout_hit = (timeout_cycles_i != 32'd0) && (r_cycle_cnt > timeout_cycles_i);
    assign w_drop_sum    = {1'b0, r_drop_cnt} + 33'(w_n);

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
            if (w_push_ok && w_elig[i]) begin
                r_mem[w_waddr[i]]      <= rvfi_i[i];
                r_port_mem[w_waddr[i]] <= PW'(i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + w_push_cnt[AW-1:0];
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_level  <= r_level + w_push_cnt - LW'(w_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cycle_cnt <= '0;
            r_drop_cnt  <= '0;
            r_overflow  <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            if (r_cycle_cnt != 32'hFFFF_FFFF) begin
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            end
            if (w_drop) begin
                r_drop_cnt <= w_drop_sum[32] ? 32'hFFFF_FFFF : w_drop_sum[31:0];
                r_overflow <= 1'b1;
            end
            // An ecall in the same cycle takes precedence, so the timeout flag stays clear.
            if ((r_state == ST_RUN) && !w_ecall_hit && w_timeout_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_ecall_hit || w_timeout_hit) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_level == '0) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE:  w_state_next = ST_DONE;
            default:  w_state_next = ST_RUN;
        endcase
    end

    always_comb begin
        w_capture_en = 1'b0;
        w_halt       = 1'b0;
        case (r_state)
            ST_RUN:  w_capture_en = 1'b1;
            ST_DONE: w_halt       = 1'b1;
            default: ;
        endcase
    end

    assign out_valid_o  = (r_level != '0);
    assign out_rvfi_o   = out_valid_o ? r_mem[r_rd_ptr] : '0;
    assign out_port_o   = out_valid_o ? r_port_mem[r_rd_ptr] : '0;
    assign fifo_level_o = r_level;
    assign overflow_o   = r_overflow;
    assign drop_cnt_o   = r_drop_cnt;
    assign timeout_o    = r_timeout;
    assign halt_o       = w_halt;

endmodule
